cube_selector_receiver: RTL and testbench



---
 rtl/cube_selector_receiver_if.sv | 33 +++
 rtl/cube_selector_receiver.sv | 115 +++++++++++
 tb/tb_cube_selector_receiver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cube_selector_receiver_if.sv
// Selector pulse lines from the button CPLD and the mode/light state presented to the pattern engine.
interface cube_selector_receiver_if #(
    parameter int MODE_W  = 3,
    parameter int LEVEL_W = 2
);
    logic               mode_selector_n;
    logic               light_selector_n;
    logic [MODE_W-1:0]  mode_index;
    logic [LEVEL_W-1:0] light_level;
    logic               mode_strobe;
    logic               light_strobe;
    logic [1:0]         stuck;

    modport master (
        output mode_selector_n,
        output light_selector_n,
        input  mode_index,
        input  light_level,
        input  mode_strobe,
        input  light_strobe,
        input  stuck
    );

    modport slave (
        input  mode_selector_n,
        input  light_selector_n,
        output mode_index,
        output light_level,
        output mode_strobe,
        output light_strobe,
        output stuck
    );
endinterface

// File: rtl/cube_selector_receiver.sv
// Two independent selector channels: synchronize, pulse-width qualify, and advance a wrapping
// mode index / light level with one-cycle change strobes and stuck-low flags.
module cube_selector_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 16,
    parameter int MIN_LOW_CYCLES = 16,
    parameter int MAX_LOW_CYCLES = 50000,
    parameter int NUM_MODES      = 8,
    parameter int MODE_W         = 3,
    parameter int NUM_LEVELS     = 4,
    parameter int LEVEL_W        = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    cube_selector_receiver_if.slave  bus
);
    localparam int FL_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {DISARMED, IDLE, LOW, STUCK} state_t;

    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [1:0]             line_n;
    logic [1:0]             s;
    state_t                 state_q [2];
    state_t                 state_d [2];
    logic [CNT_W-1:0]       cnt_q [2];
    logic [CNT_W-1:0]       cnt_d [2];
    logic [1:0]             accept;
    logic [FL_W-1:0]        flush_q;
    logic                   flushed;
    logic [MODE_W-1:0]      mode_index_q;
    logic [LEVEL_W-1:0]     light_level_q;
    logic                   mode_strobe_q;
    logic                   light_strobe_q;

    function automatic logic [MODE_W-1:0] wrap_mode(input logic [MODE_W-1:0] v);
        return (v == MODE_W'(NUM_MODES - 1)) ? '0 : v + MODE_W'(1);
    endfunction

    function automatic logic [LEVEL_W-1:0] wrap_level(input logic [LEVEL_W-1:0] v);
        return (v == LEVEL_W'(NUM_LEVELS - 1)) ? '0 : v + LEVEL_W'(1);
    endfunction

    assign line_n  = {bus.light_selector_n, bus.mode_selector_n};
    assign s       = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
    // The synchronizer's reset value of 1 is not a real observation; arming waits for real samples.
    assign flushed = (flush_q == FL_W'(SYNC_STAGES));

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            accept[ch]  = 1'b0;
            case (state_q[ch])
                DISARMED: if (flushed && s[ch]) state_d[ch] = IDLE;
                IDLE: begin
                    if (!s[ch]) begin
                        state_d[ch] = LOW;
                        cnt_d[ch]   = CNT_W'(1);
                    end
                end
                LOW: begin
                    if (!s[ch]) begin
                        if (cnt_q[ch] == CNT_W'(MAX_LOW_CYCLES)) state_d[ch] = STUCK;
                        else                                      cnt_d[ch]   = cnt_q[ch] + CNT_W'(1);
                    end else begin
                        accept[ch]  = (cnt_q[ch] >= CNT_W'(MIN_LOW_CYCLES));
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = '0;
                    end
                end
                STUCK: begin
                    cnt_d[ch] = '0;
                    if (s[ch]) state_d[ch] = IDLE;
                end
                default: begin
                    state_d[ch] = DISARMED;
                    cnt_d[ch]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                sync_q[ch]  <= '1;
                state_q[ch] <= DISARMED;
                cnt_q[ch]   <= '0;
            end
            flush_q        <= '0;
            mode_index_q   <= '0;
            light_level_q  <= '0;
            mode_strobe_q  <= 1'b0;
            light_strobe_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                sync_q[ch]  <= {sync_q[ch][SYNC_STAGES-2:0], line_n[ch]};
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            if (!flushed) flush_q <= flush_q + FL_W'(1);
            mode_strobe_q  <= accept[0];
            light_strobe_q <= accept[1];
            if (accept[0]) mode_index_q  <= wrap_mode(mode_index_q);
            if (accept[1]) light_level_q <= wrap_level(light_level_q);
        end
    end

    assign bus.mode_index   = mode_index_q;
    assign bus.light_level  = light_level_q;
    assign bus.mode_strobe  = mode_strobe_q;
    assign bus.light_strobe = light_strobe_q;
    assign bus.stuck        = {state_q[1] == STUCK, state_q[0] == STUCK};
endmodule

// File: tb/tb_cube_selector_receiver.sv
// Directed bench for cube_selector_receiver: arming, width boundary, wrap, stuck, simultaneous, reset mid-pulse.
module tb_cube_selector_receiver;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mode_strobes  = 0;
    int   light_strobes = 0;
    int   m0;
    int   l0;

    cube_selector_receiver_if #(.MODE_W(3), .LEVEL_W(2)) bus ();

    cube_selector_receiver #(
        .SYNC_STAGES(2), .CNT_W(16), .MIN_LOW_CYCLES(16), .MAX_LOW_CYCLES(1000),
        .NUM_MODES(8), .MODE_W(3), .NUM_LEVELS(4), .LEVEL_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mode_strobe)  mode_strobes++;
        if (bus.light_strobe) light_strobes++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_val(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic pulse(input bit m, input bit l, input int n);
        if (m) bus.mode_selector_n  = 1'b0;
        if (l) bus.light_selector_n = 1'b0;
        tick(n);
        bus.mode_selector_n  = 1'b1;
        bus.light_selector_n = 1'b1;
        tick(25);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(6);
    endtask

    initial begin
        bus.mode_selector_n  = 1'b0;
        bus.light_selector_n = 1'b1;
        tick(4);
        check_val("rst_mode_index",  int'(bus.mode_index), 0);
        check_val("rst_light_level", int'(bus.light_level), 0);
        check_val("rst_strobes",     int'({bus.mode_strobe, bus.light_strobe}), 0);
        check_val("rst_stuck",       int'(bus.stuck), 0);

        // Line held low through reset release must be ignored.
        reset = 1'b0;
        tick(100);
        bus.mode_selector_n = 1'b1;
        tick(10);
        check_val("arm_no_strobe", mode_strobes, 0);
        check_val("arm_index",     int'(bus.mode_index), 0);

        bus.mode_selector_n = 1'b0;
        tick(20);
        bus.mode_selector_n = 1'b1;
        tick(2);
        check_val("lat_edge2_strobe", int'(bus.mode_strobe), 0);
        check_val("lat_edge2_index",  int'(bus.mode_index), 0);
        tick(1);
        check_val("lat_edge3_strobe", int'(bus.mode_strobe), 1);
        check_val("lat_edge3_index",  int'(bus.mode_index), 1);
        tick(1);
        check_val("lat_edge4_strobe", int'(bus.mode_strobe), 0);
        tick(20);
        check_val("arm_strobe_count", mode_strobes, 1);

        do_reset();
        m0 = mode_strobes;
        pulse(1'b1, 1'b0, 15);
        check_val("width15_index", int'(bus.mode_index), 0);
        pulse(1'b1, 1'b0, 16);
        check_val("width16_index", int'(bus.mode_index), 1);
        pulse(1'b1, 1'b0, 17);
        check_val("width17_index", int'(bus.mode_index), 2);
        check_val("width_strobes", mode_strobes - m0, 2);

        do_reset();
        m0 = mode_strobes;
        l0 = light_strobes;
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1, 1'b0, 20);
            check_val($sformatf("wrap_mode_%0d", i), int'(bus.mode_index), (i + 1) % 8);
        end
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0, 1'b1, 20);
            check_val($sformatf("wrap_light_%0d", i), int'(bus.light_level), (i + 1) % 4);
        end
        check_val("wrap_mode_strobes",  mode_strobes - m0, 8);
        check_val("wrap_light_strobes", light_strobes - l0, 4);

        l0 = light_strobes;
        bus.light_selector_n = 1'b0;
        tick(1002);
        check_val("stuck_before", int'(bus.stuck), 0);
        tick(1);
        check_val("stuck_rise", int'(bus.stuck), 2);
        tick(197);
        bus.light_selector_n = 1'b1;
        tick(2);
        check_val("stuck_hold", int'(bus.stuck), 2);
        tick(1);
        check_val("stuck_fall", int'(bus.stuck), 0);
        tick(20);
        check_val("stuck_no_strobe",   light_strobes - l0, 0);
        check_val("stuck_level_keep",  int'(bus.light_level), 0);

        m0 = mode_strobes;
        l0 = light_strobes;
        bus.mode_selector_n  = 1'b0;
        bus.light_selector_n = 1'b0;
        tick(30);
        bus.mode_selector_n  = 1'b1;
        bus.light_selector_n = 1'b1;
        tick(3);
        check_val("sim_strobes",     int'({bus.mode_strobe, bus.light_strobe}), 3);
        check_val("sim_mode_index",  int'(bus.mode_index), 1);
        check_val("sim_light_level", int'(bus.light_level), 1);
        tick(1);
        check_val("sim_strobes_off", int'({bus.mode_strobe, bus.light_strobe}), 0);
        tick(20);
        check_val("sim_mode_count",  mode_strobes - m0, 1);
        check_val("sim_light_count", light_strobes - l0, 1);

        m0 = mode_strobes;
        bus.mode_selector_n = 1'b0;
        tick(9);
        reset = 1'b1;
        tick(1);
        check_val("midrst_mode_index",  int'(bus.mode_index), 0);
        check_val("midrst_light_level", int'(bus.light_level), 0);
        check_val("midrst_stuck",       int'(bus.stuck), 0);
        reset = 1'b0;
        tick(20);
        bus.mode_selector_n = 1'b1;
        tick(20);
        check_val("midrst_no_strobe", mode_strobes - m0, 0);
        check_val("midrst_index",     int'(bus.mode_index), 0);
        pulse(1'b1, 1'b0, 20);
        check_val("midrst_rearmed",   int'(bus.mode_index), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
